// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between pipeline writeback (port 0) and a long-latency unit (port 1).
// Also holds the pending-write scoreboard that decode uses to stall on outstanding port-1 results.
module regfile_wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [4:0]  p0_rdc,
  input  logic [31:0] p0_data,

  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [4:0]  p1_rdc,
  input  logic [31:0] p1_data,

  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [4:0]  iss_rdc,

  input  logic [4:0]  q_rsc,
  input  logic [4:0]  q_rtc,
  output logic        busy_rs,
  output logic        busy_rt,

  output logic        rf_we,
  output logic [4:0]  rf_rdc,
  output logic [31:0] rf_rd,
  output logic [5:0]  pend_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] pend_q, pend_d;
  logic [5:0]  pend_cnt_q;
  logic        rf_we_q;
  logic [4:0]  rf_rdc_q;
  logic [31:0] rf_rd_q;

  logic force1;
  logic p0_acc;
  logic p1_acc;
  logic iss_acc;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

  // Handshakes: port 0 wins unless port 1 has waited STARVE_MAX cycles.
  assign force1    = (wait_cnt_q == STARVE_LIM);
  assign p0_ready  = !force1;
  assign p1_ready  = force1 | !p0_valid;
  assign iss_ready = !pend_q[iss_rdc] | (iss_rdc == 5'd0);

  // Nothing is accepted while reset is asserted, even if a ready is high.
  assign p0_acc  = p0_valid  & p0_ready  & !rst;
  assign p1_acc  = p1_valid  & p1_ready  & !rst;
  assign iss_acc = iss_valid & iss_ready & !rst;

  assign busy_rs  = pend_q[q_rsc];
  assign busy_rt  = pend_q[q_rtc];
  assign pend_cnt = pend_cnt_q;
  assign rf_we    = rf_we_q;
  assign rf_rdc   = rf_rdc_q;
  assign rf_rd    = rf_rd_q;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!p1_valid || p1_acc) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != STARVE_LIM) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Clear first, then set: a new issue supersedes a retiring write to the same register.
  always_comb begin
    pend_d = pend_q;
    if (p1_acc) begin
      pend_d[p1_rdc] = 1'b0;
    end
    if (iss_acc && (iss_rdc != 5'd0)) begin
      pend_d[iss_rdc] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 4'd0;
      pend_q     <= 32'd0;
      pend_cnt_q <= 6'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      pend_q     <= pend_d;
      pend_cnt_q <= popcount32(pend_d);
    end
  end

  // Registered write port; index/data hold when idle, r0 writes are suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q  <= 1'b0;
      rf_rdc_q <= 5'd0;
      rf_rd_q  <= 32'd0;
    end else if (p0_acc) begin
      rf_we_q  <= (p0_rdc != 5'd0);
      rf_rdc_q <= p0_rdc;
      rf_rd_q  <= p0_data;
    end else if (p1_acc) begin
      rf_we_q  <= (p1_rdc != 5'd0);
      rf_rdc_q <= p1_rdc;
      rf_rd_q  <= p1_data;
    end else begin
      rf_we_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_valid, p0_ready;
  logic [4:0]  p0_rdc;
  logic [31:0] p0_data;
  logic        p1_valid, p1_ready;
  logic [4:0]  p1_rdc;
  logic [31:0] p1_data;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rdc;
  logic [4:0]  q_rsc, q_rtc;
  logic        busy_rs, busy_rt;
  logic        rf_we;
  logic [4:0]  rf_rdc;
  logic [31:0] rf_rd;
  logic [5:0]  pend_cnt;

  int n_chk;
  int n_fail;

  regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rdc(p0_rdc), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_rdc(p1_rdc), .p1_data(p1_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rdc(iss_rdc),
    .q_rsc(q_rsc), .q_rtc(q_rtc), .busy_rs(busy_rs), .busy_rt(busy_rt),
    .rf_we(rf_we), .rf_rdc(rf_rdc), .rf_rd(rf_rd), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    p0_valid = 1'b1; p0_rdc = 5'd3; p0_data = 32'h1111_1111;
    p1_valid = 1'b1; p1_rdc = 5'd4; p1_data = 32'h2222_2222;
    iss_valid = 1'b1; iss_rdc = 5'd7;
    q_rsc = 5'd7; q_rtc = 5'd4;

    // Reset with every valid asserted
    step();
    step();
    chk("rst_we", rf_we, 0);
    chk("rst_cnt", pend_cnt, 0);
    chk("rst_busy_rs", busy_rs, 0);
    chk("rst_busy_rt", busy_rt, 0);
    chk("rst_rd", rf_rd, 0);
    rst = 1'b0;
    p0_valid = 1'b0; p1_valid = 1'b0; iss_valid = 1'b0;
    step();
    chk("post_rst_we", rf_we, 0);
    chk("post_rst_rdc", rf_rdc, 0);

    // Simple port-0 write
    p0_valid = 1'b1; p0_rdc = 5'd5; p0_data = 32'h1234_5678;
    #1 chk("simple_p0_ready", p0_ready, 1);
    step();
    p0_valid = 1'b0;
    chk("simple_we", rf_we, 1);
    chk("simple_rdc", rf_rdc, 5);
    chk("simple_rd", rf_rd, 32'h1234_5678);
    step();
    chk("simple_we_drop", rf_we, 0);
    chk("simple_rdc_hold", rf_rdc, 5);

    // Writes and issues to r0
    p1_valid = 1'b1; p1_rdc = 5'd0; p1_data = 32'hAAAA_AAAA;
    #1 chk("zero_p1_ready", p1_ready, 1);
    step();
    p1_valid = 1'b0;
    chk("zero_we", rf_we, 0);
    iss_valid = 1'b1; iss_rdc = 5'd0;
    #1 chk("zero_iss_ready", iss_ready, 1);
    step();
    iss_valid = 1'b0;
    chk("zero_cnt", pend_cnt, 0);

    // Starvation: both ports held valid; port 1 forced through on the 5th cycle
    p0_valid = 1'b1; p0_rdc = 5'd1; p0_data = 32'h0000_0100;
    p1_valid = 1'b1; p1_rdc = 5'd2; p1_data = 32'h0000_0200;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("starve_p0_ready_%0d", c), p0_ready, (c != 4));
      chk($sformatf("starve_p1_ready_%0d", c), p1_ready, (c == 4));
      step();
      chk($sformatf("starve_we_%0d", c), rf_we, 1);
      chk($sformatf("starve_rdc_%0d", c), rf_rdc, (c == 4) ? 2 : 1);
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    step();
    chk("starve_idle_we", rf_we, 0);

    // Scoreboard set / WAW stall / clear by port-1 write
    q_rsc = 5'd9; q_rtc = 5'd9;
    iss_valid = 1'b1; iss_rdc = 5'd9;
    #1 chk("sb_iss_ready", iss_ready, 1);
    step();
    iss_valid = 1'b0;
    chk("sb_cnt_set", pend_cnt, 1);
    chk("sb_busy_rs", busy_rs, 1);
    chk("sb_busy_rt", busy_rt, 1);
    iss_valid = 1'b1; iss_rdc = 5'd9;
    #1 chk("sb_reissue_ready", iss_ready, 0);
    step();
    iss_valid = 1'b0;
    chk("sb_cnt_after_stall", pend_cnt, 1);
    p1_valid = 1'b1; p1_rdc = 5'd9; p1_data = 32'hDEAD_BEEF;
    #1 chk("sb_p1_ready", p1_ready, 1);
    step();
    p1_valid = 1'b0;
    chk("sb_busy_clear", busy_rs, 0);
    chk("sb_rd", rf_rd, 32'hDEAD_BEEF);
    chk("sb_we", rf_we, 1);
    chk("sb_cnt_clear", pend_cnt, 0);

    // Same-edge clear and set on r9: set wins
    iss_valid = 1'b1; iss_rdc = 5'd9;
    p1_valid = 1'b1; p1_rdc = 5'd9; p1_data = 32'h0000_0055;
    #1;
    chk("sim_iss_ready", iss_ready, 1);
    chk("sim_p1_ready", p1_ready, 1);
    step();
    iss_valid = 1'b0; p1_valid = 1'b0;
    chk("sim_busy", busy_rs, 1);
    chk("sim_cnt", pend_cnt, 1);
    chk("sim_we", rf_we, 1);
    chk("sim_rdc", rf_rdc, 9);

    // Port-1 write to a non-pending register leaves the scoreboard alone
    p1_valid = 1'b1; p1_rdc = 5'd4; p1_data = 32'h4444_4444;
    step();
    p1_valid = 1'b0;
    chk("nonpend_we", rf_we, 1);
    chk("nonpend_rd", rf_rd, 32'h4444_4444);
    chk("nonpend_cnt", pend_cnt, 1);
    chk("nonpend_busy", busy_rs, 1);

    // Reset mid-operation with a request presented
    p0_valid = 1'b1; p0_rdc = 5'd6; p0_data = 32'h6666_6666;
    rst = 1'b1;
    step();
    chk("midrst_we", rf_we, 0);
    chk("midrst_cnt", pend_cnt, 0);
    chk("midrst_busy", busy_rs, 0);
    rst = 1'b0;
    p0_valid = 1'b0;
    step();
    chk("midrst_after_we", rf_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
